alu_sub16_seq: RTL and testbench

//  Multi-cycle 16-bit subtract sequencer for the 8085 ALU datapath (DSUB-style ops).

---
 rtl/alu_sub16_seq_pkg.sv | 19 +
 rtl/alu_sub16_seq_sub8b.sv | 31 +++
 rtl/alu_sub16_seq.sv | 161 ++++++++++++++++
 tb/tb_alu_sub16_seq.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/alu_sub16_seq_pkg.sv
// Shared types for the 16-bit subtract sequencer: FSM encoding and flag-register bit positions.
// Pure declarations; no logic, no latency, no flow control.
package alu_sub16_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LO   = 2'd1,
        ST_HI   = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // Bit positions used when these flags are packed into the 8085 flag register.
    localparam int FLAG_S  = 7;
    localparam int FLAG_Z  = 6;
    localparam int FLAG_AC = 4;
    localparam int FLAG_P  = 2;
    localparam int FLAG_CY = 0;

endpackage

// File: rtl/alu_sub16_seq_sub8b.sv
// Combinational byte subtractor: oD = iJ - iK - iB, oB[i] = borrow out of bit i, oP = even parity of oD.
// Zero latency; purely combinational, no backpressure.
module alu_sub16_seq_sub8b #(
    parameter int DATASIZE = 8
) (
    input  logic [DATASIZE-1:0] iJ,
    input  logic [DATASIZE-1:0] iK,
    input  logic [DATASIZE-1:0] iB,
    output logic [DATASIZE-1:0] oD,
    output logic [DATASIZE-1:0] oB,
    output logic                oP
);

    logic [DATASIZE+1:0] mask;
    logic [DATASIZE+1:0] part;

    // Borrow out of bit i is the sign of the difference restricted to bits [i:0].
    always_comb begin
        oD   = iJ - iK - iB;
        oP   = ~^oD;
        oB   = '0;
        mask = '0;
        part = '0;
        for (int i = 0; i < DATASIZE; i++) begin
            mask  = ((DATASIZE+2)'(1) << (i + 1)) - (DATASIZE+2)'(1);
            part  = ({2'b00, iJ} & mask) - ({2'b00, iK} & mask) - ({2'b00, iB} & mask);
            oB[i] = part[DATASIZE+1];
        end
    end

endmodule

// File: rtl/alu_sub16_seq.sv
// Two-pass 16-bit subtract (low byte, then high byte with chained borrow); registers difference and S/Z/P/CY flags.
// Latency: start sampled on edge N+1, oDone high after edge N+3; iStart ignored while busy. ALU_SUB16_OVF_EN adds oV.
module alu_sub16_seq
    import alu_sub16_seq_pkg::*;
#(
    parameter int DATASIZE = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  iStart,
    input  logic [2*DATASIZE-1:0] iJ,
    input  logic [2*DATASIZE-1:0] iK,
    input  logic                  iB,
    output logic                  oBusy,
    output logic                  oDone,
    output logic [2*DATASIZE-1:0] oD,
    output logic                  oCY,
    output logic                  oZ,
    output logic                  oS,
    output logic                  oP
`ifdef ALU_SUB16_OVF_EN
   ,output logic                  oV
`endif
);

    localparam int W = 2 * DATASIZE;

    state_t                state_q, state_d;
    logic [W-1:0]          j_q, j_d, k_q, k_d;
    logic                  b_q, b_d;
    logic [DATASIZE-1:0]   lo_q, lo_d;
    logic                  brw_q, brw_d;
    logic [W-1:0]          d_q, d_d;
    logic                  cy_q, cy_d, z_q, z_d, s_q, s_d, p_q, p_d;
    logic                  v_q, v_d;

    logic [DATASIZE-1:0]   sub_j, sub_k, sub_bin, sub_d, sub_b;
    logic                  sub_p;
    logic [W-1:0]          word;
    logic                  unused_ok;

    assign unused_ok = ^{sub_b[DATASIZE-2:0], sub_p};

    always_comb begin
        sub_j   = j_q[DATASIZE-1:0];
        sub_k   = k_q[DATASIZE-1:0];
        sub_bin = {{(DATASIZE-1){1'b0}}, b_q};
        if (state_q == ST_HI) begin
            sub_j   = j_q[W-1:DATASIZE];
            sub_k   = k_q[W-1:DATASIZE];
            sub_bin = {{(DATASIZE-1){1'b0}}, brw_q};
        end
    end

    alu_sub16_seq_sub8b #(.DATASIZE(DATASIZE)) u_sub8b (
        .iJ (sub_j),
        .iK (sub_k),
        .iB (sub_bin),
        .oD (sub_d),
        .oB (sub_b),
        .oP (sub_p)
    );

    assign word = {sub_d, lo_q};

    always_comb begin
        state_d = state_q;
        j_d     = j_q;
        k_d     = k_q;
        b_d     = b_q;
        lo_d    = lo_q;
        brw_d   = brw_q;
        d_d     = d_q;
        cy_d    = cy_q;
        z_d     = z_q;
        s_d     = s_q;
        p_d     = p_q;
        v_d     = v_q;
        case (state_q)
            ST_IDLE: begin
                if (iStart) begin
                    j_d     = iJ;
                    k_d     = iK;
                    b_d     = iB;
                    state_d = ST_LO;
                end
            end
            ST_LO: begin
                lo_d    = sub_d;
                brw_d   = sub_b[DATASIZE-1];
                state_d = ST_HI;
            end
            ST_HI: begin
                d_d     = word;
                cy_d    = sub_b[DATASIZE-1];
                z_d     = (word == '0);
                s_d     = word[W-1];
                p_d     = ~^word;
                v_d     = (j_q[W-1] != k_q[W-1]) && (word[W-1] != j_q[W-1]);
                state_d = ST_DONE;
            end
            ST_DONE: begin
                if (iStart) begin
                    j_d     = iJ;
                    k_d     = iK;
                    b_d     = iB;
                    state_d = ST_LO;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            j_q     <= '0;
            k_q     <= '0;
            b_q     <= 1'b0;
            lo_q    <= '0;
            brw_q   <= 1'b0;
            d_q     <= '0;
            cy_q    <= 1'b0;
            z_q     <= 1'b0;
            s_q     <= 1'b0;
            p_q     <= 1'b0;
            v_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            j_q     <= j_d;
            k_q     <= k_d;
            b_q     <= b_d;
            lo_q    <= lo_d;
            brw_q   <= brw_d;
            d_q     <= d_d;
            cy_q    <= cy_d;
            z_q     <= z_d;
            s_q     <= s_d;
            p_q     <= p_d;
            v_q     <= v_d;
        end
    end

    assign oBusy = (state_q == ST_LO) || (state_q == ST_HI);
    assign oDone = (state_q == ST_DONE);
    assign oD    = d_q;
    assign oCY   = cy_q;
    assign oZ    = z_q;
    assign oS    = s_q;
    assign oP    = p_q;
`ifdef ALU_SUB16_OVF_EN
    assign oV    = v_q;
`else
    // Overflow is not exposed in this build; the register is left for synthesis to trim.
    logic unused_v;
    assign unused_v = v_q;
`endif

endmodule

// File: tb/tb_alu_sub16_seq.sv
// Self-checking bench for alu_sub16_seq: directed cases, ignored restart, reset mid-op, random sweep.
// Expected values come from integer arithmetic on the operands.
module tb_alu_sub16_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        iStart;
    logic [15:0] iJ, iK;
    logic        iB;
    logic        oBusy, oDone, oCY, oZ, oS, oP;
    logic [15:0] oD;
`ifdef ALU_SUB16_OVF_EN
    logic        oV;
`endif

    int err_cnt = 0;
    int chk_cnt = 0;

    always #5 clk = ~clk;

    alu_sub16_seq #(.DATASIZE(8)) dut (
        .clk    (clk),
        .rst    (rst),
        .iStart (iStart),
        .iJ     (iJ),
        .iK     (iK),
        .iB     (iB),
        .oBusy  (oBusy),
        .oDone  (oDone),
        .oD     (oD),
        .oCY    (oCY),
        .oZ     (oZ),
        .oS     (oS),
        .oP     (oP)
`ifdef ALU_SUB16_OVF_EN
       ,.oV     (oV)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // One operation; poke_lo re-asserts iStart with J=FFFF while the op is in LO.
    task automatic run_op(input logic [15:0] j, input logic [15:0] k, input logic b, input bit poke_lo);
        int          diff, sdiff, cyc;
        logic [15:0] exp_d;
        bit          got;
        diff  = int'(j) - int'(k) - int'(b);
        sdiff = int'($signed(j)) - int'($signed(k)) - int'(b);
        exp_d = 16'(diff);
        iJ = j; iK = k; iB = b; iStart = 1'b1;
        cyc = 0; got = 1'b0;
        while (!got && cyc < 8) begin
            @(posedge clk); #1;
            cyc++;
            if (cyc == 1) begin
                chk("busy_lo", oBusy, 1'b1);
                if (poke_lo) begin
                    iJ = 16'hFFFF; iK = 16'($urandom); iB = 1'($urandom); iStart = 1'b1;
                end else begin
                    iJ = 16'($urandom); iK = 16'($urandom); iB = 1'($urandom); iStart = 1'b0;
                end
            end else begin
                iStart = 1'b0;
            end
            if (oDone) got = 1'b1;
        end
        chk("done_seen", got, 1'b1);
        chk("latency", cyc, 3);
        chk("d", oD, exp_d);
        chk("cy", oCY, (int'(j) < int'(k) + int'(b)));
        chk("z", oZ, (exp_d == 16'h0));
        chk("s", oS, (diff < 0) ? (diff + 65536 >= 32768) : (diff >= 32768));
        chk("p", oP, ($countones(exp_d) % 2 == 0));
`ifdef ALU_SUB16_OVF_EN
        chk("v", oV, (sdiff > 32767 || sdiff < -32768));
`else
        if (sdiff > 99999) chk("v_range", 1'b0, 1'b1);
`endif
    endtask

    initial begin
        logic [15:0] hold_d;
        rst = 1'b1; iStart = 1'b0; iJ = '0; iK = '0; iB = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", oBusy, 1'b0);
        chk("rst_done", oDone, 1'b0);
        chk("rst_d", oD, 16'h0);
        chk("rst_flags", {oCY, oZ, oS, oP}, 4'h0);
`ifdef ALU_SUB16_OVF_EN
        chk("rst_v", oV, 1'b0);
`endif
        rst = 1'b0;
        @(posedge clk); #1;

        run_op(16'h1234, 16'h0235, 1'b0, 1'b0);
        run_op(16'h0000, 16'h0001, 1'b0, 1'b0);
        run_op(16'h0100, 16'h00FF, 1'b1, 1'b0);
        run_op(16'h8000, 16'h0001, 1'b0, 1'b0);

        // Result holds and oDone drops once back in IDLE.
        hold_d = oD;
        @(posedge clk); #1;
        chk("done_pulse", oDone, 1'b0);
        chk("idle_busy", oBusy, 1'b0);
        chk("hold_d", oD, hold_d);
        @(posedge clk); #1;

        // Restart during LO is ignored; the next start from DONE runs back to back.
        run_op(16'h1234, 16'h0235, 1'b0, 1'b1);
        chk("ignored_d", oD, 16'h0FFF);
        run_op(16'h0001, 16'h0002, 1'b1, 1'b0);

        // Reset asserted in HI wins: no update, no oDone.
        iJ = 16'h1234; iK = 16'h0235; iB = 1'b0; iStart = 1'b1;
        @(posedge clk); #1;
        iStart = 1'b0;
        @(posedge clk); #1;
        chk("hi_busy", oBusy, 1'b1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("mrst_busy", oBusy, 1'b0);
        chk("mrst_done", oDone, 1'b0);
        chk("mrst_d", oD, 16'h0);
        chk("mrst_flags", {oCY, oZ, oS, oP}, 4'h0);
`ifdef ALU_SUB16_OVF_EN
        chk("mrst_v", oV, 1'b0);
`endif
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            chk("mrst_nodone", oDone, 1'b0);
        end

        for (int n = 0; n < 10000; n++) begin
            run_op(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom_range(0, 7) == 0));
        end

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
